imem_fetch_buf: RTL and testbench

Parametrised synchronous instruction memory with a valid/ready fetch interface and an output buffer, the next generation of the combinational `instruction_mem`. Sits between the PC/fetch-stage logic and the IF/ID pipeline register of the pipelined RISC-V core. Accepts one fetch address per cycle, reads the word array synchronously, and queues {instruction, PC, fault} in a small FIFO so decode back-pressure and branch flushes are absorbed without losing or duplicating fetches.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_fetch_buf_if.sv | 25 ++
 rtl/imem_fifo.sv | 58 +++++
 rtl/imem_fetch_buf.sv | 72 +++++++
 tb/tb_imem_fetch_buf.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types for the instruction fetch buffer: fetch entry layout and the empty-slot NOP.
// Latency: n/a (types only).
// Backpressure: n/a.
package imem_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: '0, fault: 1'b0};

endpackage

// File: rtl/imem_fetch_buf_if.sv
// Fetch request / response bundle between the PC stage and the IF/ID register.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response sides.
interface imem_fetch_buf_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [XLEN-1:0] A_instr;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rsp_pc;
    logic            rsp_fault;
    logic            rsp_ready;

    modport master (
        output req_valid, A_instr, rsp_ready,
        input  req_ready, rsp_valid, instr, rsp_pc, rsp_fault
    );

    modport slave (
        input  req_valid, A_instr, rsp_ready,
        output req_ready, rsp_valid, instr, rsp_pc, rsp_fault
    );
endinterface

// File: rtl/imem_fifo.sv
// Small FIFO of fetch entries with occupancy count and synchronous flush.
// Latency: push at edge N is visible at the head right after edge N.
// Backpressure: caller must not push when full unless popping in the same cycle.
module imem_fifo
    import imem_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    output logic             head_vld,
    output fetch_entry_t     head_dat,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop && head_vld;
    assign head_dat = head_vld ? mem[rd_ptr] : EMPTY_ENTRY;

    // Flush outranks any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)
                count <= count + 1'b1;
            else if (!push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/imem_fetch_buf.sv
// Instruction memory with synchronous read straight into an output FIFO; IMEM_FAULT_EN adds fault checking.
// Latency: 1 cycle from accepted request to entry at the FIFO head; 1 fetch/cycle sustained.
// Backpressure: req_ready drops when the FIFO is full and the head is not being taken, or during flush.
module imem_fetch_buf
    import imem_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 256,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  flush,
    imem_fetch_buf_if.slave      bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  INSTR_MEM [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             fault;
    logic             push;
    logic             pop;
    logic             head_vld;
    fetch_entry_t     push_dat;
    fetch_entry_t     head_dat;
    logic [CNT_W-1:0] count;

    assign idx = IDX_W'((bus.A_instr - BASE_ADDR) >> 2);

`ifdef IMEM_FAULT_EN
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * DEPTH);
    logic [XLEN-1:0] offset;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
    assign offset = bus.A_instr - BASE_ADDR;
    assign fault  = (bus.A_instr[1:0] != 2'b00) || (offset >= MEM_BYTES);
`else
    assign fault  = 1'b0;
`endif

    assign push_dat.instr = fault ? NOP_INSTR : INSTR_MEM[idx];
    assign push_dat.pc    = bus.A_instr;
    assign push_dat.fault = fault;

    assign pop           = head_vld && bus.rsp_ready;
    assign bus.req_ready = !flush && ((count < CNT_W'(FIFO_DEPTH)) || pop);
    assign push          = bus.req_valid && bus.req_ready;

    imem_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (count)
    );

    assign bus.rsp_valid = head_vld;
    assign bus.instr     = head_dat.instr;
    assign bus.rsp_pc    = head_dat.pc;
    assign bus.rsp_fault = head_dat.fault;

endmodule

// File: tb/tb_imem_fetch_buf.sv
// Randomised and directed bench for imem_fetch_buf against a queue-based reference model.
module tb_imem_fetch_buf;

    localparam int          DEPTH = 256;
    localparam int          FD    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    imem_fetch_buf_if #(.XLEN(32)) bus ();

    imem_fetch_buf #(
        .XLEN       (32),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] golden [DEPTH];
    exp_t        q [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t        e;
        logic [31:0] off;
        off     = a - BASE;
        e.pc    = a;
        e.fault = 1'b0;
        e.instr = golden[(off / 4) % DEPTH];
`ifdef IMEM_FAULT_EN
        if ((a % 4) != 0 || off >= 4 * DEPTH) begin
            e.fault = 1'b1;
            e.instr = NOP;
        end
`endif
        return e;
    endfunction

    task automatic check_outputs(input logic exp_rdy);
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("count", dut.count, q.size());
        if (q.size() > 0) begin
            chk("rsp_valid", bus.rsp_valid, 1'b1);
            chk("instr", bus.instr, q[0].instr);
            chk("rsp_pc", bus.rsp_pc, q[0].pc);
            chk("rsp_fault", bus.rsp_fault, q[0].fault);
        end else begin
            chk("rsp_valid", bus.rsp_valid, 1'b0);
            chk("instr_empty", bus.instr, NOP);
            chk("rsp_pc_empty", bus.rsp_pc, 32'h0);
            chk("rsp_fault_empty", bus.rsp_fault, 1'b0);
        end
    endtask

    // One clock cycle: drive after the falling edge, check just before the rising edge, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic fl);
        logic exp_rdy;
        @(negedge clk);
        bus.req_valid = v;
        bus.A_instr   = a;
        bus.rsp_ready = rr;
        flush         = fl;
        #1;
        exp_rdy = !fl && (q.size() < FD || (q.size() > 0 && rr));
        check_outputs(exp_rdy);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rr)
                void'(q.pop_front());
            if (v && exp_rdy)
                q.push_back(model_fetch(a));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < FD + 1; i++)
            step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.A_instr   = 32'h0;
        bus.rsp_ready = 1'b0;

        golden[0] = 32'h0000_0013;
        golden[1] = 32'h0010_0093;
        golden[2] = 32'h0020_0113;
        golden[3] = 32'h0030_8193;
        for (int i = 4; i < DEPTH; i++)
            golden[i] = $urandom;
        for (int i = 0; i < DEPTH; i++)
            dut.INSTR_MEM[i] = golden[i];

        #3;
        check_outputs(1'b1);
        #10;
        rst_n = 1'b1;

        // Back-to-back fetches with the consumer always ready.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(i * 4), 1'b1, 1'b0);
        drain();

        // Stalled consumer: third request must be refused until the head is taken.
        step(1'b1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd8, 1'b0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0);
        step(1'b1, 32'd12, 1'b1, 1'b0);
        drain();

        // Flush with two buffered entries and a live request.
        step(1'b1, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd12, 1'b0, 1'b0);
        step(1'b1, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'd8, 1'b1, 1'b0);
        drain();

        // Misaligned and out-of-range addresses.
        step(1'b1, 32'd1024, 1'b1, 1'b0);
        step(1'b1, 32'd2, 1'b1, 1'b0);
        step(1'b1, 32'd1028, 1'b1, 1'b0);
        drain();

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd8, 1'b0, 1'b0);
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_outputs(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0:       a = $urandom_range(0, 4095);
                1:       a = 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            step(($urandom % 4) != 0, a, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
